// File: rtl/voice_allocator_if.sv
// Handshake bundle between the note front end / envelope bank and the voice allocator.
interface voice_allocator_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_W      = 7
);
    logic                          on_valid;
    logic [KEY_W-1:0]              on_key;
    logic                          on_ready;
    logic                          off_valid;
    logic [KEY_W-1:0]              off_key;
    logic [NUM_VOICES-1:0]         env_busy;
    logic [NUM_VOICES-1:0]         env_note_on;
    logic [NUM_VOICES-1:0]         env_note_off;
    logic [NUM_VOICES*KEY_W-1:0]   voice_key;
    logic [NUM_VOICES-1:0]         voice_held;
    logic                          steal;

    modport master (
        output on_valid, on_key, off_valid, off_key, env_busy,
        input  on_ready, env_note_on, env_note_off, voice_key, voice_held, steal
    );

    modport slave (
        input  on_valid, on_key, off_valid, off_key, env_busy,
        output on_ready, env_note_on, env_note_off, voice_key, voice_held, steal
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns key-ons to free envelope generators, routes key-offs,
// and steals the oldest held voice when the bank is full.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_W      = 7,
    parameter int unsigned AGE_W      = 4
) (
    input logic              clk,
    input logic              rst,
    voice_allocator_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [2:0] {StIdle, StAlloc, StSteal, StWait} state_e;

    state_e                               state_q;
    logic                                 on_ready_q;
    logic                                 steal_q;
    logic [NUM_VOICES-1:0]                note_on_q;
    logic [NUM_VOICES-1:0]                note_off_q;
    logic [NUM_VOICES-1:0]                held_q;
    logic [NUM_VOICES-1:0][KEY_W-1:0]     key_q;
    logic [NUM_VOICES-1:0][AGE_W-1:0]     age_q;
    logic [KEY_W-1:0]                     pend_key_q;
    logic [IDX_W-1:0]                     victim_q;

    logic [NUM_VOICES-1:0] off_match;
    logic [NUM_VOICES-1:0] held_eff;
    logic [NUM_VOICES-1:0] free;
    logic                  free_any;
    logic [IDX_W-1:0]      free_idx;
    logic                  hit_any;
    logic [IDX_W-1:0]      hit_idx;
    logic                  old_found;
    logic [IDX_W-1:0]      old_idx;
    logic [AGE_W-1:0]      old_age;

    always_comb begin
        off_match = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            off_match[v] = bus.off_valid && held_q[v] && (key_q[v] == bus.off_key);
        end
        // Key-offs take effect before any decision made in the same cycle.
        held_eff = held_q & ~off_match;
        free     = ~bus.env_busy & ~held_q;
        free_any = |free;

        free_idx = '0;
        hit_any  = 1'b0;
        hit_idx  = '0;
        for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
            if (free[v]) begin
                free_idx = IDX_W'(v);
            end
            if (held_eff[v] && (key_q[v] == bus.on_key)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(v);
            end
        end

        // Strict compare keeps the lowest index on age ties.
        old_found = 1'b0;
        old_idx   = '0;
        old_age   = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (held_eff[v] && (!old_found || (age_q[v] > old_age))) begin
                old_found = 1'b1;
                old_idx   = IDX_W'(v);
                old_age   = age_q[v];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            on_ready_q <= 1'b0;
            steal_q    <= 1'b0;
            note_on_q  <= '0;
            note_off_q <= '0;
            held_q     <= '0;
            key_q      <= '0;
            age_q      <= '0;
            pend_key_q <= '0;
            victim_q   <= '0;
        end else begin
            note_on_q  <= '0;
            note_off_q <= off_match;
            steal_q    <= 1'b0;
            held_q     <= held_eff;
            case (state_q)
                StIdle: begin
                    on_ready_q <= 1'b1;
                    if (bus.on_valid && on_ready_q) begin
                        on_ready_q <= 1'b0;
                        pend_key_q <= bus.on_key;
                        if (hit_any) begin
                            victim_q <= hit_idx;
                            state_q  <= StSteal;
                        end else begin
                            state_q <= StAlloc;
                        end
                    end
                end
                StAlloc: begin
                    if (free_any) begin
                        for (int v = 0; v < int'(NUM_VOICES); v++) begin
                            if (held_eff[v] && (age_q[v] != AGE_MAX)) begin
                                age_q[v] <= age_q[v] + 1'b1;
                            end
                        end
                        note_on_q[free_idx] <= 1'b1;
                        key_q[free_idx]     <= pend_key_q;
                        held_q[free_idx]    <= 1'b1;
                        age_q[free_idx]     <= '0;
                        on_ready_q          <= 1'b1;
                        state_q             <= StIdle;
                    end else if (old_found) begin
                        victim_q <= old_idx;
                        state_q  <= StSteal;
                    end
                end
                StSteal: begin
                    note_off_q[victim_q] <= 1'b1;
                    held_q[victim_q]     <= 1'b0;
                    steal_q              <= 1'b1;
                    state_q              <= StWait;
                end
                StWait: begin
                    if (!bus.env_busy[victim_q]) begin
                        state_q <= StAlloc;
                    end
                end
                default: begin
                    on_ready_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign bus.on_ready     = on_ready_q;
    assign bus.env_note_on  = note_on_q;
    assign bus.env_note_off = note_off_q;
    assign bus.voice_key    = key_q;
    assign bus.voice_held   = held_q;
    assign bus.steal        = steal_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: expected pulses are queued by the stimulus and
// popped by a monitor whenever the DUT emits note_on/note_off/steal.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int KW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    voice_allocator_if #(.NUM_VOICES(NV), .KEY_W(KW)) bus ();

    voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Envelope bank stand-in: busy from note_on until rel_len cycles after note_off.
    logic [NV-1:0] busy_r = '0;
    logic [NV-1:0] busy_force = '0;
    logic [NV-1:0] force_req = '0;
    int            rcnt [NV];
    int            rel_len = 2;

    always @(posedge clk) begin
        busy_force <= force_req;
        for (int v = 0; v < NV; v++) begin
            if (rst) begin
                busy_r[v] <= 1'b0;
                rcnt[v]   <= 0;
            end else if (bus.env_note_on[v]) begin
                busy_r[v] <= 1'b1;
                rcnt[v]   <= 0;
            end else if (bus.env_note_off[v]) begin
                rcnt[v] <= rel_len;
            end else if (rcnt[v] != 0) begin
                rcnt[v] <= rcnt[v] - 1;
                if (rcnt[v] == 1) busy_r[v] <= 1'b0;
            end
        end
    end
    assign bus.env_busy = busy_r | busy_force;

    typedef struct {
        int           cyc;
        logic [NV-1:0] on;
        logic [NV-1:0] off;
        logic          st;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    function automatic void push(input int c, input logic [NV-1:0] on, input logic [NV-1:0] off,
                                 input logic st);
        exp_t n;
        n.cyc = c;
        n.on  = on;
        n.off = off;
        n.st  = st;
        exp_q.push_back(n);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse at cyc %0d: expected on=%b off=%b steal=%b at cyc %0d",
                     cyc, exp_q[0].on, exp_q[0].off, exp_q[0].st, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if ((bus.env_note_on | bus.env_note_off) != '0 || bus.steal) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc %0d: got on=%b off=%b steal=%b, none required",
                         cyc, bus.env_note_on, bus.env_note_off, bus.steal);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.on !== bus.env_note_on ||
                    mon_e.off !== bus.env_note_off || mon_e.st !== bus.steal) begin
                    errors++;
                    $display("FAIL pulse cyc %0d on=%b off=%b steal=%b, required cyc %0d on=%b off=%b steal=%b",
                             cyc, bus.env_note_on, bus.env_note_off, bus.steal,
                             mon_e.cyc, mon_e.on, mon_e.off, mon_e.st);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [KW-1:0] vkey(input int v);
        return bus.voice_key[v*KW +: KW];
    endfunction

    task automatic wait_ready();
        int budget = 200;
        while (!bus.on_ready && budget > 0) begin
            step(1);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL on_ready_timeout: got 0, required 1 (cyc %0d)", cyc);
        end
    endtask

    // Returns the accept cycle.
    task automatic issue_on(input logic [KW-1:0] key, output int t);
        bus.on_valid = 1'b1;
        bus.on_key   = key;
        wait_ready();
        t = cyc;
        step(1);
        bus.on_valid = 1'b0;
    endtask

    task automatic issue_off(input logic [KW-1:0] key, output int t);
        bus.off_valid = 1'b1;
        bus.off_key   = key;
        t = cyc;
        step(1);
        bus.off_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic fill4(input logic [KW-1:0] k0, input logic [KW-1:0] k1,
                         input logic [KW-1:0] k2, input logic [KW-1:0] k3);
        int t;
        issue_on(k0, t); push(t + 2, 4'b0001, 4'b0000, 1'b0);
        issue_on(k1, t); push(t + 2, 4'b0010, 4'b0000, 1'b0);
        issue_on(k2, t); push(t + 2, 4'b0100, 4'b0000, 1'b0);
        issue_on(k3, t); push(t + 2, 4'b1000, 4'b0000, 1'b0);
        wait_cyc(t + 2);
    endtask

    initial begin
        int t;
        int x;
        int hi;
        int budget;
        bus.on_valid  = 1'b0;
        bus.on_key    = '0;
        bus.off_valid = 1'b0;
        bus.off_key   = '0;

        // 1: reset state, first allocation
        step(3);
        chk("rst_on_ready", 32'(bus.on_ready), 0);
        chk("rst_held", 32'(bus.voice_held), 0);
        chk("rst_voice_key", bus.voice_key, 0);
        chk("rst_steal", 32'(bus.steal), 0);
        rst = 1'b0;
        step(1);
        chk("ready_after_rst", 32'(bus.on_ready), 1);
        issue_on(7'd60, t);
        push(t + 2, 4'b0001, 4'b0000, 1'b0);
        chk("ready_low_alloc", 32'(bus.on_ready), 0);
        wait_cyc(t + 2);
        chk("ready_back_t2", 32'(bus.on_ready), 1);
        chk("t1_held", 32'(bus.voice_held), 32'h1);
        chk("t1_key0", 32'(vkey(0)), 60);

        // 2: key-off routing, reuse of the released voice
        issue_on(7'd62, t); push(t + 2, 4'b0010, 4'b0000, 1'b0);
        issue_on(7'd64, t); push(t + 2, 4'b0100, 4'b0000, 1'b0);
        wait_cyc(t + 2);
        chk("t2_held3", 32'(bus.voice_held), 32'h7);
        issue_off(7'd62, x);
        push(x + 1, 4'b0000, 4'b0010, 1'b0);
        chk("t2_held_after_off", 32'(bus.voice_held), 32'h5);
        issue_off(7'd99, x);
        budget = 50;
        while (bus.env_busy[1] && budget > 0) begin
            step(1);
            budget--;
        end
        issue_on(7'd65, t); push(t + 2, 4'b0010, 4'b0000, 1'b0);
        wait_cyc(t + 2);
        chk("t2_key1", 32'(vkey(1)), 65);
        chk("t2_held", 32'(bus.voice_held), 32'h7);

        // 3: steal the oldest voice, long release
        do_reset();
        fill4(7'd60, 7'd62, 7'd64, 7'd65);
        rel_len = 10;
        issue_on(7'd67, t);
        push(t + 3, 4'b0000, 4'b0001, 1'b1);
        push(t + 16, 4'b0001, 4'b0000, 1'b0);
        hi = 0;
        for (int c = t + 1; c <= t + 15; c++) begin
            wait_cyc(c);
            if (bus.on_ready) hi++;
            if (c == t + 3) chk("t3_held_after_steal", 32'(bus.voice_held), 32'he);
        end
        chk("t3_ready_low_cycles", 32'(hi), 0);
        wait_cyc(t + 16);
        chk("t3_ready_back", 32'(bus.on_ready), 1);
        chk("t3_key0", 32'(vkey(0)), 67);
        chk("t3_held", 32'(bus.voice_held), 32'hf);

        // 4: re-press of a held key retriggers that voice only
        rel_len = 3;
        issue_on(7'd64, t);
        push(t + 2, 4'b0000, 4'b0100, 1'b1);
        push(t + 8, 4'b0100, 4'b0000, 1'b0);
        wait_cyc(t + 8);
        chk("t4_key2", 32'(vkey(2)), 64);
        chk("t4_key1", 32'(vkey(1)), 62);
        chk("t4_held", 32'(bus.voice_held), 32'hf);

        // 5: all voices releasing, none held
        do_reset();
        force_req = 4'b1111;
        step(2);
        issue_on(7'd50, t);
        wait_cyc(t + 8);
        chk("t5_ready_low", 32'(bus.on_ready), 0);
        chk("t5_held_none", 32'(bus.voice_held), 0);
        force_req = 4'b0111;
        x = cyc;
        push(x + 2, 4'b1000, 4'b0000, 1'b0);
        wait_cyc(x + 2);
        chk("t5_key3", 32'(vkey(3)), 50);
        chk("t5_held", 32'(bus.voice_held), 32'h8);
        force_req = 4'b0000;
        step(3);

        // 6: reset while waiting on a stolen voice
        do_reset();
        fill4(7'd10, 7'd11, 7'd12, 7'd13);
        rel_len = 20;
        issue_on(7'd14, t);
        push(t + 3, 4'b0000, 4'b0001, 1'b1);
        wait_cyc(t + 5);
        rst = 1'b1;
        step(1);
        chk("t6_ready", 32'(bus.on_ready), 0);
        chk("t6_held", 32'(bus.voice_held), 0);
        chk("t6_key", bus.voice_key, 0);
        chk("t6_note_on", 32'(bus.env_note_on), 0);
        rst = 1'b0;
        step(1);
        chk("t6_ready_after", 32'(bus.on_ready), 1);
        step(30);

        // 7: key-off and key-on of the same key together allocate fresh
        rel_len = 4;
        issue_on(7'd30, t); push(t + 2, 4'b0001, 4'b0000, 1'b0);
        wait_cyc(t + 2);
        wait_ready();
        bus.on_valid  = 1'b1;
        bus.on_key    = 7'd30;
        bus.off_valid = 1'b1;
        bus.off_key   = 7'd30;
        x = cyc;
        push(x + 1, 4'b0000, 4'b0001, 1'b0);
        push(x + 2, 4'b0010, 4'b0000, 1'b0);
        step(1);
        bus.on_valid  = 1'b0;
        bus.off_valid = 1'b0;
        wait_cyc(x + 2);
        chk("t7_key1", 32'(vkey(1)), 30);
        chk("t7_held", 32'(bus.voice_held), 32'h2);

        step(5);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end
endmodule
